// File: rtl/l1b_pkg.sv
// rtl/l1b_pkg.sv - shared types and constants for the host cycle sequencer
//
// Contents:
//   host_state_t : host cycle FSM states (IDLE, WAIT_R, HOST, DONE)
//   CFG_MAP_LO   : config bit mapping bank-0 $0000-$7FFF to local RAM
//   CFG_ERR_CLR  : config bit whose write-as-1 clears the sticky timeout flag
//   in_low_half  : true for bank-0 offsets below $8000
package l1b_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_R = 2'd1,
        HOST   = 2'd2,
        DONE   = 2'd3
    } host_state_t;

    localparam int CFG_MAP_LO  = 0;
    localparam int CFG_ERR_CLR = 7;

    function automatic logic in_low_half(input logic [15:0] addr);
        return ~addr[15];
    endfunction

endpackage

// File: rtl/host_cycle_sequencer_phase_sync.sv
// rtl/host_cycle_sequencer_phase_sync.sv - phi0 synchroniser with edge pulses
//
// Module phase_sync
//   clk     in   fast system clock
//   rst     in   asynchronous active-high reset
//   phi0    in   host phi0, asynchronous to clk
//   ph_rise out  one-clk pulse after a synchronised rising edge of phi0
//   ph_fall out  one-clk pulse after a synchronised falling edge of phi0
module phase_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic phi0,
    output logic ph_rise,
    output logic ph_fall
);

    // sync_q[0] is the first (metastability-facing) flop, sync_q[STAGES-1] the last.
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], phi0};
        end
    end

    // Edges are taken between the last two stages, so sync_q[STAGES-2] is the newer sample.
    assign ph_rise =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign ph_fall = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/host_cycle_sequencer.sv
// rtl/host_cycle_sequencer.sv - 65816 bus cycle sequencer for local RAM / host bus
//
// Decodes each CPU bus cycle to local RAM, the config register or the host,
// and runs host cycles aligned to the synchronised host phi0, holding the CPU
// on rdy until the host cycle has finished or timed out.
//
// Optional feature macro: HOST_POST_WR_EN (posted host writes, 1-entry buffer).
//
// Ports:
//   bbc_ck8      in   sole clock
//   rst          in   asynchronous active-high reset
//   bbc_ck_phi0  in   host phi0 (asynchronous)
//   cyc_start    in   one-cycle pulse at start of each CPU bus cycle
//   cpu_addr     in   {bank, addr}, valid at cyc_start
//   cpu_vda      in   valid data address
//   cpu_vpa      in   valid program address
//   cpu_rdnw     in   1 = read
//   cpu_wdata    in   write data, valid at cyc_start
//   cfg_rdata    out  config register readback
//   rdy          out  0 = hold CPU
//   ram_ceb      out  RAM chip enable, active low
//   ram_addr_hi  out  RAM address bits above a15
//   host_en      out  host bus cycle in progress
//   host_rdnw    out  host direction
//   host_wdata   out  host write data
//   err          out  sticky host timeout flag
module host_cycle_sequencer
    import l1b_pkg::*;
#(
    parameter int          RAM_AW      = 19,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] CFG_ADDR    = 16'hFEF0,
    parameter int          TIMEOUT     = 255
) (
    input  logic              bbc_ck8,
    input  logic              rst,
    input  logic              bbc_ck_phi0,
    input  logic              cyc_start,
    input  logic [23:0]       cpu_addr,
    input  logic              cpu_vda,
    input  logic              cpu_vpa,
    input  logic              cpu_rdnw,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cfg_rdata,
    output logic              rdy,
    output logic              ram_ceb,
    output logic [RAM_AW-17:0] ram_addr_hi,
    output logic              host_en,
    output logic              host_rdnw,
    output logic [7:0]        host_wdata,
    output logic              err
);

    logic        ph_rise;
    logic        ph_fall;
    host_state_t state;
    logic [7:0]  cfg;
    logic [7:0]  tmo_cnt;
    logic        req_rdnw;
    logic [7:0]  req_wdata;

    logic        accept;
    logic        bank0;
    logic        dec_act;
    logic        hit_cfg;
    logic        hit_ram;
    logic        hit_host;
    logic        tmo_hit;
    logic        tmo_fire;
    logic        launch_go;
    logic        launch_rdnw;
    logic [7:0]  launch_wdata;

    phase_sync #(
        .STAGES (SYNC_STAGES)
    ) u_phase_sync (
        .clk     (bbc_ck8),
        .rst     (rst),
        .phi0    (bbc_ck_phi0),
        .ph_rise (ph_rise),
        .ph_fall (ph_fall)
    );

`ifdef HOST_POST_WR_EN
    // The req_* registers act as the post buffer while a posted write runs.
    // A host access arriving meanwhile parks in pend_* with rdy held low.
    logic       pend_vld;
    logic       pend_rdnw;
    logic [7:0] pend_wdata;

    assign accept       = cyc_start & rdy & ~pend_vld;
    assign launch_go    = (state == IDLE) & (pend_vld | hit_host);
    assign launch_rdnw  = pend_vld ? pend_rdnw  : cpu_rdnw;
    assign launch_wdata = pend_vld ? pend_wdata : cpu_wdata;
`else
    // cyc_start outside IDLE cannot happen legally (rdy is low), so it is dropped.
    assign accept       = cyc_start & (state == IDLE);
    assign launch_go    = hit_host;
    assign launch_rdnw  = cpu_rdnw;
    assign launch_wdata = cpu_wdata;
`endif

    assign bank0    = (cpu_addr[23:16] == 8'h00);
    assign dec_act  = accept & (cpu_vda | cpu_vpa);
    assign hit_cfg  = dec_act & bank0 & (cpu_addr[15:0] == CFG_ADDR);
    assign hit_ram  = dec_act & ~hit_cfg &
                      (~bank0 | (in_low_half(cpu_addr[15:0]) & cfg[CFG_MAP_LO]));
    assign hit_host = dec_act & ~hit_cfg & ~hit_ram;

    // A phi0 edge in the same cycle as the last count still wins over the timeout.
    assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));
    assign tmo_fire = tmo_hit & (((state == WAIT_R) & ~ph_rise) |
                                 ((state == HOST)   & ~ph_fall));

    assign cfg_rdata = cfg;

    always_ff @(posedge bbc_ck8 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            rdy         <= 1'b1;
            ram_ceb     <= 1'b1;
            ram_addr_hi <= '0;
            host_en     <= 1'b0;
            host_rdnw   <= 1'b1;
            host_wdata  <= '0;
            err         <= 1'b0;
            cfg         <= '0;
            req_rdnw    <= 1'b1;
            req_wdata   <= '0;
`ifdef HOST_POST_WR_EN
            pend_vld    <= 1'b0;
            pend_rdnw   <= 1'b1;
            pend_wdata  <= '0;
`endif
        end else begin
            // Every accepted cycle closes the previous RAM window.
            if (accept) begin
                ram_ceb <= ~hit_ram;
            end
            // Bank bits above the RAM size simply wrap; bank 0 yields zero.
            if (hit_ram) begin
                ram_addr_hi <= cpu_addr[RAM_AW-1:16];
            end
            if (hit_cfg && !cpu_rdnw) begin
                cfg <= cpu_wdata;
            end

            case (state)
                IDLE: begin
                    // phi0 edges are ignored here; a decode coinciding with
                    // ph_rise waits in WAIT_R for the following rise.
                    if (launch_go) begin
                        state     <= WAIT_R;
                        tmo_cnt   <= '0;
                        req_rdnw  <= launch_rdnw;
                        req_wdata <= launch_wdata;
`ifdef HOST_POST_WR_EN
                        // Writes are posted and release the CPU; reads hold it.
                        rdy       <= ~launch_rdnw;
                        pend_vld  <= 1'b0;
`else
                        rdy       <= 1'b0;
`endif
                    end
                end
                WAIT_R: begin
                    if (ph_rise) begin
                        state      <= HOST;
                        tmo_cnt    <= '0;
                        host_en    <= 1'b1;
                        host_rdnw  <= req_rdnw;
                        host_wdata <= req_wdata;
                    end else if (tmo_hit) begin
                        state   <= DONE;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                HOST: begin
                    if (ph_fall || tmo_hit) begin
                        state   <= DONE;
                        tmo_cnt <= '0;
                        host_en <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef HOST_POST_WR_EN
                    // A parked access keeps the CPU held until it is launched.
                    rdy   <= ~pend_vld;
`else
                    rdy   <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef HOST_POST_WR_EN
            // Host access while the post buffer is busy: park it and hold the CPU.
            if (hit_host && (state != IDLE)) begin
                pend_vld   <= 1'b1;
                pend_rdnw  <= cpu_rdnw;
                pend_wdata <= cpu_wdata;
                rdy        <= 1'b0;
            end
`endif

            if (tmo_fire) begin
                err <= 1'b1;
            end else if (hit_cfg && !cpu_rdnw && cpu_wdata[CFG_ERR_CLR]) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_host_cycle_sequencer.sv
// tb/tb_host_cycle_sequencer.sv - directed self-checking bench for host_cycle_sequencer
module tb_host_cycle_sequencer;

    logic        bbc_ck8     = 1'b0;
    logic        rst         = 1'b1;
    logic        bbc_ck_phi0 = 1'b0;
    logic        cyc_start   = 1'b0;
    logic [23:0] cpu_addr    = '0;
    logic        cpu_vda     = 1'b0;
    logic        cpu_vpa     = 1'b0;
    logic        cpu_rdnw    = 1'b1;
    logic [7:0]  cpu_wdata   = '0;
    logic [7:0]  cfg_rdata;
    logic        rdy;
    logic        ram_ceb;
    logic [2:0]  ram_addr_hi;
    logic        host_en;
    logic        host_rdnw;
    logic [7:0]  host_wdata;
    logic        err;

    logic        phi_en = 1'b1;
    int          n_assert = 0;
    int          n_fail   = 0;

    host_cycle_sequencer dut (
        .bbc_ck8     (bbc_ck8),
        .rst         (rst),
        .bbc_ck_phi0 (bbc_ck_phi0),
        .cyc_start   (cyc_start),
        .cpu_addr    (cpu_addr),
        .cpu_vda     (cpu_vda),
        .cpu_vpa     (cpu_vpa),
        .cpu_rdnw    (cpu_rdnw),
        .cpu_wdata   (cpu_wdata),
        .cfg_rdata   (cfg_rdata),
        .rdy         (rdy),
        .ram_ceb     (ram_ceb),
        .ram_addr_hi (ram_addr_hi),
        .host_en     (host_en),
        .host_rdnw   (host_rdnw),
        .host_wdata  (host_wdata),
        .err         (err)
    );

    always #5 bbc_ck8 = ~bbc_ck8;

    // phi0: period 8 clocks, edges on clock falling edges; held low when disabled.
    initial begin
        forever begin
            #40;
            if (phi_en) bbc_ck_phi0 = ~bbc_ck_phi0;
            else        bbc_ck_phi0 = 1'b0;
        end
    end

    task automatic tick();
        @(posedge bbc_ck8);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [23:0] a, input logic vda, input logic vpa,
                         input logic rdnw, input logic [7:0] wd);
        cyc_start = 1'b1;
        cpu_addr  = a;
        cpu_vda   = vda;
        cpu_vpa   = vpa;
        cpu_rdnw  = rdnw;
        cpu_wdata = wd;
        tick();
        cyc_start = 1'b0;
        cpu_vda   = 1'b0;
        cpu_vpa   = 1'b0;
    endtask

    task automatic wait_en(input logic val, input int max);
        int n = 0;
        while (host_en !== val && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rdy(input int max);
        int n = 0;
        while (rdy !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int hi;
        logic saw_en;

        // Reset with phi0 toggling
        repeat (5) tick();
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_ceb", ram_ceb, 1'b1);
        chk("rst_addr_hi", ram_addr_hi, 3'd0);
        chk("rst_host_en", host_en, 1'b0);
        chk("rst_host_rdnw", host_rdnw, 1'b1);
        chk("rst_host_wdata", host_wdata, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_cfg", cfg_rdata, 8'h00);
        rst = 1'b0;
        saw_en = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (host_en === 1'b1) saw_en = 1'b1;
        end
        chk("idle_no_host_en", saw_en, 1'b0);

        // Host read 00:FC00
        issue(24'h00FC00, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("rd_rdy_drop", rdy, 1'b0);
        chk("rd_ceb", ram_ceb, 1'b1);
        wait_en(1'b1, 40);
        chk("rd_host_en", host_en, 1'b1);
        chk("rd_host_rdnw", host_rdnw, 1'b1);
        chk("rd_rdy_held", rdy, 1'b0);
        hi = 1;
        while (host_en === 1'b1 && hi < 20) begin
            tick();
            if (host_en === 1'b1) hi++;
        end
        chk("rd_en_width", hi, 4);
        chk("rd_rdy_done", rdy, 1'b0);
        tick();
        chk("rd_rdy_back", rdy, 1'b1);

        // RAM decodes in non-zero banks, with wrap
        issue(24'h051234, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("ram5_ceb", ram_ceb, 1'b0);
        chk("ram5_hi", ram_addr_hi, 3'b101);
        chk("ram5_rdy", rdy, 1'b1);
        issue(24'h0A0000, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("ramA_hi", ram_addr_hi, 3'b010);
        chk("ramA_ceb", ram_ceb, 1'b0);
        issue(24'h002000, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("internal_ceb", ram_ceb, 1'b1);
        chk("internal_rdy", rdy, 1'b1);

        // Map low bank 0 to RAM
        issue(24'h00FEF0, 1'b1, 1'b0, 1'b0, 8'h01);
        chk("cfgw_rdy", rdy, 1'b1);
        chk("cfgw_rdata", cfg_rdata, 8'h01);
        chk("cfgw_ceb", ram_ceb, 1'b1);
        issue(24'h001000, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("map_ceb", ram_ceb, 1'b0);
        chk("map_hi", ram_addr_hi, 3'd0);
        chk("map_rdy", rdy, 1'b1);

`ifdef HOST_POST_WR_EN
        // Two back-to-back posted writes
        issue(24'h00FE20, 1'b1, 1'b0, 1'b0, 8'h11);
        chk("post1_rdy", rdy, 1'b1);
        issue(24'h00FE21, 1'b1, 1'b0, 1'b0, 8'h22);
        chk("post2_hold", rdy, 1'b0);
        wait_en(1'b1, 40);
        chk("post1_wdata", host_wdata, 8'h11);
        chk("post1_rdnw", host_rdnw, 1'b0);
        chk("post2_still_held", rdy, 1'b0);
        wait_en(1'b0, 20);
        wait_en(1'b1, 60);
        chk("post2_wdata", host_wdata, 8'h22);
        chk("post2_rdy", rdy, 1'b1);
        wait_en(1'b0, 20);
        repeat (3) tick();
`else
        // Held host write
        issue(24'h00FE20, 1'b1, 1'b0, 1'b0, 8'h5A);
        chk("wr_rdy_drop", rdy, 1'b0);
        wait_en(1'b1, 40);
        chk("wr_host_en", host_en, 1'b1);
        chk("wr_host_rdnw", host_rdnw, 1'b0);
        chk("wr_host_wdata", host_wdata, 8'h5A);
        wait_en(1'b0, 20);
        wait_rdy(4);
        chk("wr_rdy_back", rdy, 1'b1);
`endif

        // Timeout with phi0 held low
        phi_en = 1'b0;
        repeat (20) tick();
        issue(24'h00FE40, 1'b1, 1'b0, 1'b1, 8'h00);
        repeat (254) tick();
        chk("tmo_err_early", err, 1'b0);
        chk("tmo_rdy_early", rdy, 1'b0);
        tick();
        chk("tmo_err_set", err, 1'b1);
        chk("tmo_host_en", host_en, 1'b0);
        tick();
        chk("tmo_rdy_back", rdy, 1'b1);
        chk("tmo_err_sticky", err, 1'b1);

        // Clear err, unmap low bank 0: 00:1000 becomes a host cycle
        issue(24'h00FEF0, 1'b1, 1'b0, 1'b0, 8'h80);
        chk("clr_err", err, 1'b0);
        chk("clr_cfg", cfg_rdata, 8'h80);
        phi_en = 1'b1;
        issue(24'h001000, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("unmap_rdy", rdy, 1'b0);
        chk("unmap_ceb", ram_ceb, 1'b1);
        wait_en(1'b1, 40);
        chk("unmap_host_en", host_en, 1'b1);
        wait_en(1'b0, 20);
        wait_rdy(4);
        chk("unmap_rdy_back", rdy, 1'b1);

        // Reset in the middle of a host cycle
        issue(24'h00FD00, 1'b1, 1'b0, 1'b1, 8'h00);
        wait_en(1'b1, 40);
        chk("mid_host_en", host_en, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_host_en", host_en, 1'b0);
        chk("mid_rst_rdy", rdy, 1'b1);
        chk("mid_rst_cfg", cfg_rdata, 8'h00);
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
